// File: rtl/gcm_result_collector.sv
// Result collector for the GCM wrapper: buffers cipher blocks and tags in a
// first-word-fall-through FIFO and re-issues them as a valid/ready stream,
// with a per-message block count attached to each tag entry.
module gcm_result_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cp_ready,
    input  logic [0:127]             i_cipher_text,
    input  logic [288:0]             i_bypass_text,
    input  logic                     i_tag_ready,
    input  logic [0:127]             i_tag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [0:127]             o_data,
    output logic [288:0]             o_bypass,
    output logic                     o_is_tag,
    output logic                     o_last,
    output logic [CNT_W-1:0]         o_msg_blocks,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    // Entry storage, one array per field
    logic [0:127]     data_mem [DEPTH];
    logic [288:0]     byp_mem  [DEPTH];
    logic             tag_mem  [DEPTH];
    logic [CNT_W-1:0] cnt_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             ovf_q, ovf_d;
    logic [0:127]     pend_tag_q, pend_tag_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;

    logic             empty, full, pop, space;
    logic [CNT_W-1:0] blk_inc;
    logic             wr_req, wr_en;
    logic [0:127]     wr_data;
    logic [288:0]     wr_byp;
    logic             wr_is_tag;
    logic [CNT_W-1:0] wr_cnt;
    logic [AW-1:0]    rd_idx;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop     = !empty && i_ready;
    assign space   = !full || pop;
    assign blk_inc = (&blk_cnt_q) ? blk_cnt_q : blk_cnt_q + CNT_W'(1);
    assign rd_idx  = rd_ptr_q[AW-1:0];

    // Tag sequencing, block counting, overflow detection and write-port mux
    always_comb begin
        state_d    = state_q;
        blk_cnt_d  = blk_cnt_q;
        ovf_d      = ovf_q;
        pend_tag_d = pend_tag_q;
        pend_cnt_d = pend_cnt_q;
        wr_req     = 1'b0;
        wr_data    = '0;
        wr_byp     = '0;
        wr_is_tag  = 1'b0;
        wr_cnt     = '0;
        case (state_q)
            IDLE: begin
                if (i_cp_ready) begin
                    wr_req  = 1'b1;
                    wr_data = i_cipher_text;
                    wr_byp  = i_bypass_text;
                    if (!space) ovf_d = 1'b1;
                    if (i_tag_ready) begin
                        // Tag waits one cycle behind its own last block
                        pend_tag_d = i_tag;
                        pend_cnt_d = blk_inc;
                        blk_cnt_d  = '0;
                        state_d    = PEND;
                    end else begin
                        blk_cnt_d = blk_inc;
                    end
                end else if (i_tag_ready) begin
                    blk_cnt_d = '0;
                    if (space) begin
                        wr_req    = 1'b1;
                        wr_data   = i_tag;
                        wr_is_tag = 1'b1;
                        wr_cnt    = blk_cnt_q;
                    end else begin
                        // No room: park the tag and retry rather than drop it
                        pend_tag_d = i_tag;
                        pend_cnt_d = blk_cnt_q;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                if (i_tag_ready) ovf_d = 1'b1;
                if (i_cp_ready) begin
                    // Cipher of the next message wins the write port
                    wr_req    = 1'b1;
                    wr_data   = i_cipher_text;
                    wr_byp    = i_bypass_text;
                    if (!space) ovf_d = 1'b1;
                    blk_cnt_d = blk_inc;
                end else if (space) begin
                    wr_req    = 1'b1;
                    wr_data   = pend_tag_q;
                    wr_is_tag = 1'b1;
                    wr_cnt    = pend_cnt_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_en    = wr_req && space;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            blk_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            pend_tag_q <= '0;
            pend_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            ovf_q      <= ovf_d;
            pend_tag_q <= pend_tag_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // FIFO memory write; contents are left untouched by reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            data_mem[wr_ptr_q[AW-1:0]] <= wr_data;
            byp_mem[wr_ptr_q[AW-1:0]]  <= wr_byp;
            tag_mem[wr_ptr_q[AW-1:0]]  <= wr_is_tag;
            cnt_mem[wr_ptr_q[AW-1:0]]  <= wr_cnt;
        end
    end

    // Head of FIFO, zeroed while empty
    assign o_valid      = !empty;
    assign o_data       = empty ? '0 : data_mem[rd_idx];
    assign o_bypass     = empty ? '0 : byp_mem[rd_idx];
    assign o_is_tag     = empty ? 1'b0 : tag_mem[rd_idx];
    assign o_last       = o_is_tag;
    assign o_msg_blocks = empty ? '0 : cnt_mem[rd_idx];
    assign o_level      = wr_ptr_q - rd_ptr_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_gcm_result_collector.sv
// Directed bench for gcm_result_collector with a queue-level reference model.
module tb_gcm_result_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_cp_ready;
    logic [0:127]       i_cipher_text;
    logic [288:0]       i_bypass_text;
    logic               i_tag_ready;
    logic [0:127]       i_tag;
    logic               o_valid;
    logic               i_ready;
    logic [0:127]       o_data;
    logic [288:0]       o_bypass;
    logic               o_is_tag;
    logic               o_last;
    logic [CNT_W-1:0]   o_msg_blocks;
    logic [3:0]         o_level;
    logic               o_overflow;

    gcm_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_cp_ready(i_cp_ready), .i_cipher_text(i_cipher_text), .i_bypass_text(i_bypass_text),
        .i_tag_ready(i_tag_ready), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_bypass(o_bypass),
        .o_is_tag(o_is_tag), .o_last(o_last), .o_msg_blocks(o_msg_blocks),
        .o_level(o_level), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]     data;
        logic [288:0]     byp;
        logic             is_tag;
        logic [CNT_W-1:0] blks;
    } ent_t;

    // Reference model: expected FIFO contents as a queue
    ent_t             mq[$];
    ent_t             log_q[$];
    bit               m_pend;
    ent_t             m_pend_e;
    logic [CNT_W-1:0] m_blk;
    bit               m_ovf;
    bit               started = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Apply one clock of stimulus to the model (inputs still held)
    task automatic model_step();
        int   sz;
        bit   do_pop, space;
        ent_t e;
        sz     = mq.size();
        do_pop = (sz > 0) && i_ready;
        space  = (sz < DEPTH) || do_pop;
        if (rst) begin
            mq.delete();
            m_pend = 1'b0;
            m_blk  = '0;
            m_ovf  = 1'b0;
            return;
        end
        if (do_pop) void'(mq.pop_front());
        e.data = i_cipher_text; e.byp = i_bypass_text; e.is_tag = 1'b0; e.blks = '0;
        if (m_pend) begin
            if (i_tag_ready) m_ovf = 1'b1;
            if (i_cp_ready) begin
                if (space) mq.push_back(e); else m_ovf = 1'b1;
                m_blk = sat_inc(m_blk);
            end else if (space) begin
                mq.push_back(m_pend_e);
                m_pend = 1'b0;
            end
        end else if (i_cp_ready) begin
            if (space) mq.push_back(e); else m_ovf = 1'b1;
            if (i_tag_ready) begin
                m_pend_e.data = i_tag; m_pend_e.byp = '0; m_pend_e.is_tag = 1'b1;
                m_pend_e.blks = sat_inc(m_blk);
                m_pend = 1'b1;
                m_blk  = '0;
            end else begin
                m_blk = sat_inc(m_blk);
            end
        end else if (i_tag_ready) begin
            e.data = i_tag; e.byp = '0; e.is_tag = 1'b1; e.blks = m_blk;
            m_blk = '0;
            if (space) mq.push_back(e);
            else begin m_pend_e = e; m_pend = 1'b1; end
        end
    endtask

    // Per-cycle comparison of all outputs against the model; also logs pops
    ent_t h_exp;
    ent_t rec;
    always @(negedge clk) begin
        if (started) begin
            if (mq.size() != 0) h_exp = mq[0];
            else begin h_exp.data = '0; h_exp.byp = '0; h_exp.is_tag = 1'b0; h_exp.blks = '0; end
            chk("valid",    320'(o_valid),      320'(mq.size() != 0));
            chk("data",     320'(o_data),       320'(h_exp.data));
            chk("bypass",   320'(o_bypass),     320'(h_exp.byp));
            chk("is_tag",   320'(o_is_tag),     320'(h_exp.is_tag));
            chk("last",     320'(o_last),       320'(h_exp.is_tag));
            chk("msg_blks", 320'(o_msg_blocks), 320'(h_exp.blks));
            chk("level",    320'(o_level),      320'(mq.size()));
            chk("overflow", 320'(o_overflow),   320'(m_ovf));
            if (!rst && o_valid && i_ready) begin
                rec.data = o_data; rec.byp = o_bypass; rec.is_tag = o_is_tag; rec.blks = o_msg_blocks;
                log_q.push_back(rec);
            end
        end
    end

    task automatic cyc(input bit cp, input logic [7:0] db, input logic [288:0] byp,
                       input bit tg, input logic [7:0] tb_, input bit rdy, input bit rs);
        logic [7:0] b;
        logic [7:0] t;
        b = db;
        t = tb_;
        rst           = rs;
        i_cp_ready    = cp;
        i_cipher_text = {16{b}};
        i_bypass_text = byp;
        i_tag_ready   = tg;
        i_tag         = {16{t}};
        i_ready       = rdy;
        @(posedge clk);
        model_step();
        if (rs) started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, '0, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 8'h00, '0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; i_cp_ready = 1'b0; i_tag_ready = 1'b0; i_ready = 1'b0;
        i_cipher_text = '0; i_bypass_text = '0; i_tag = '0;
        do_reset();
        do_reset();
        chk("rst_valid", 320'(o_valid), 320'(0));
        chk("rst_level", 320'(o_level), 320'(0));
        chk("rst_data",  320'(o_data),  320'(0));

        // Basic message
        log_q.delete();
        cyc(1'b1, 8'h01, 289'(1), 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h02, 289'(2), 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h03, 289'(3), 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, '0,      1'b1, 8'hAA, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("basic_cnt",    320'(log_q.size()), 320'(4));
        if (log_q.size() == 4) begin
            chk("basic_d0",   320'(log_q[0].data), 320'(128'h01010101010101010101010101010101));
            chk("basic_b0",   320'(log_q[0].byp),  320'(1));
            chk("basic_b2",   320'(log_q[2].byp),  320'(3));
            chk("basic_tag",  320'(log_q[3].is_tag), 320'(1));
            chk("basic_blks", 320'(log_q[3].blks), 320'(3));
            chk("basic_tbyp", 320'(log_q[3].byp),  320'(0));
            chk("basic_td",   320'(log_q[3].data), 320'(128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA));
        end

        // Simultaneous strobes, then next message begins immediately
        log_q.delete();
        cyc(1'b1, 8'h11, 289'(17), 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h12, 289'(18), 1'b1, 8'hBB, 1'b1, 1'b0);
        cyc(1'b1, 8'h13, 289'(19), 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1, 1'b1);
        cyc(1'b0, 8'h00, '0, 1'b1, 8'hBC, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("sim_cnt", 320'(log_q.size()), 320'(5));
        if (log_q.size() == 5) begin
            chk("sim_d2",    320'(log_q[2].data[7:0]), 320'(8'h13));
            chk("sim_tag1",  320'(log_q[3].is_tag),    320'(1));
            chk("sim_blks1", 320'(log_q[3].blks),      320'(2));
            chk("sim_blks2", 320'(log_q[4].blks),      320'(1));
        end
        chk("sim_ovf", 320'(o_overflow), 320'(0));

        // Backpressure and overflow
        log_q.delete();
        for (int k = 0; k < 9; k++)
            cyc(1'b1, 8'(8'h41 + k), 289'(k + 100), 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp_level", 320'(o_level),    320'(8));
        chk("bp_ovf",   320'(o_overflow), 320'(1));
        idle(10, 1'b1);
        chk("bp_drain", 320'(log_q.size()), 320'(8));
        if (log_q.size() == 8)
            chk("bp_last", 320'(log_q[7].data[7:0]), 320'(8'h48));
        chk("bp_ovf_sticky", 320'(o_overflow), 320'(1));
        cyc(1'b0, 8'h00, '0, 1'b1, 8'hCD, 1'b1, 1'b0);
        idle(2, 1'b1);
        if (log_q.size() == 9)
            chk("bp_tag_blks", 320'(log_q[8].blks), 320'(9));
        else
            chk("bp_tag_cnt", 320'(log_q.size()), 320'(9));

        // Full with simultaneous pop, across pointer wrap
        do_reset();
        log_q.delete();
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 8'(8'h51 + k), 289'(k), 1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 8'(8'h61 + k), 289'(k + 8), 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fp_level", 320'(o_level),    320'(8));
        chk("fp_ovf",   320'(o_overflow), 320'(0));
        idle(10, 1'b1);
        chk("fp_cnt", 320'(log_q.size()), 320'(18));
        if (log_q.size() == 18) begin
            chk("fp_d8",  320'(log_q[8].data[7:0]),  320'(8'h61));
            chk("fp_d17", 320'(log_q[17].data[7:0]), 320'(8'h6A));
        end

        // Tag arriving while full
        do_reset();
        log_q.delete();
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 8'(8'h71 + k), 289'(k), 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, '0, 1'b1, 8'hCC, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("tf_level", 320'(o_level),    320'(8));
        chk("tf_ovf",   320'(o_overflow), 320'(0));
        idle(1, 1'b1);
        chk("tf_level2", 320'(o_level), 320'(8));
        idle(10, 1'b1);
        chk("tf_cnt", 320'(log_q.size()), 320'(9));
        if (log_q.size() == 9) begin
            chk("tf_tag",  320'(log_q[8].is_tag), 320'(1));
            chk("tf_blks", 320'(log_q[8].blks),   320'(8));
        end
        chk("tf_ovf2", 320'(o_overflow), 320'(0));

        // Reset mid-message, with a strobe present during reset
        cyc(1'b1, 8'h81, 289'(1), 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h82, 289'(2), 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h83, 289'(3), 1'b1, 8'hEE, 1'b1, 1'b1);
        chk("mr_valid", 320'(o_valid), 320'(0));
        chk("mr_level", 320'(o_level), 320'(0));
        chk("mr_data",  320'(o_data),  320'(0));
        log_q.delete();
        cyc(1'b1, 8'h91, 289'(5), 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, '0, 1'b1, 8'hDD, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("mr_cnt", 320'(log_q.size()), 320'(2));
        if (log_q.size() == 2)
            chk("mr_blks", 320'(log_q[1].blks), 320'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
